// File: rtl/multi_period_measurement_unit.sv
// multi_period_measurement_unit: period/high-time meter over 2^AVG_LOG2 periods with timeout, saturation and ready/ack.
// Define GLITCH_FILTER_EN to insert a FILT_LEN-cycle stability filter after the synchroniser.
module multi_period_measurement_unit #(
   parameter int COUNT_W  = 32,
   parameter int AVG_LOG2 = 0,
   parameter int TIMEOUT  = 50_000_000,
   parameter int FILT_LEN = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               ack,
   input  logic               edge_sel,
   input  logic               signal_in,
   output logic               measurement_ready,
   output logic [COUNT_W-1:0] period_count_out,
   output logic [COUNT_W-1:0] high_time_count_out,
   output logic               timeout_out,
   output logic               saturated_out,
   output logic               level_out
);
   localparam int TW = $clog2(TIMEOUT);
   localparam int EW = AVG_LOG2 + 1;
   typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;
   generate
      if (AVG_LOG2 < 0 || AVG_LOG2 > 8 || TIMEOUT < 2 || FILT_LEN < 1) begin : g_bad_param
         $error("multi_period_measurement_unit: illegal parameter value");
      end
   endgenerate
   logic s1_q, s2_q, d_q, rise_q, fall_q, lvl;
`ifdef GLITCH_FILTER_EN
   localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   logic          filt_q;
   logic [FW-1:0] fcnt_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         filt_q <= 1'b0;
         fcnt_q <= '0;
      end else if (s2_q == filt_q) fcnt_q <= '0;
      else if (fcnt_q == FW'(FILT_LEN - 1)) begin
         filt_q <= s2_q;
         fcnt_q <= '0;
      end else fcnt_q <= fcnt_q + 1'b1;
   assign lvl = filt_q;
`else
   assign lvl = s2_q;
`endif
   // d_q is the level aligned with the registered edge pulses
   always_ff @(posedge clk or posedge reset)
      if (reset) {s1_q, s2_q, d_q, rise_q, fall_q} <= '0;
      else begin
         s1_q   <= signal_in;
         s2_q   <= s1_q;
         d_q    <= lvl;
         rise_q <= lvl & ~d_q;
         fall_q <= ~lvl & d_q;
      end
   state_t             state_q, state_d;
   logic               esel_q, esel_d, sat_q, sat_d;
   logic [COUNT_W-1:0] pacc_q, pacc_d, hacc_q, hacc_d;
   logic [EW-1:0]      ecnt_q, ecnt_d;
   logic [TW-1:0]      tmo_q, tmo_d;
   logic               rdy_q, rdy_d, tout_q, tout_d, sout_q, sout_d, lout_q, lout_d;
   logic [COUNT_W-1:0] pout_q, pout_d, hout_q, hout_d, pnext, hnext;
   logic [COUNT_W:0]   pinc, hinc;
   logic               sel_edge, tmo_hit, run, post_res, post_tmo, sat_now;
   assign sel_edge = esel_q ? fall_q : rise_q;
   assign tmo_hit  = tmo_q == TW'(TIMEOUT - 1);
   assign run      = start & (state_q == ARM || state_q == MEAS);
   assign post_res = start & (state_q == MEAS) & sel_edge & (ecnt_q == EW'((1 << AVG_LOG2) - 1));
   assign post_tmo = run & ~sel_edge & tmo_hit;
   assign pinc     = {1'b0, pacc_q} + 1'b1;
   assign hinc     = {1'b0, hacc_q} + 1'b1;
   assign pnext    = pinc[COUNT_W] ? '1 : pinc[COUNT_W-1:0];
   assign hnext    = ~d_q ? hacc_q : hinc[COUNT_W] ? '1 : hinc[COUNT_W-1:0];
   assign sat_now  = sat_q | pinc[COUNT_W] | (d_q & hinc[COUNT_W]);
   always_comb begin
      state_d = state_q;
      esel_d  = esel_q;
      pacc_d  = pacc_q;
      hacc_d  = hacc_q;
      ecnt_d  = ecnt_q;
      tmo_d   = tmo_q;
      sat_d   = sat_q;
      rdy_d   = rdy_q;
      tout_d  = tout_q;
      sout_d  = sout_q;
      lout_d  = lout_q;
      pout_d  = pout_q;
      hout_d  = hout_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = ARM;
            esel_d  = edge_sel;
            tmo_d   = '0;
         end
         ARM: if (!start) state_d = IDLE;
            else if (sel_edge) begin
               state_d = MEAS;
               {pacc_d, hacc_d, ecnt_d, tmo_d, sat_d} = '0;
            end else tmo_d = tmo_q + 1'b1;
         MEAS: if (!start) state_d = IDLE;
            else begin
               pacc_d = pnext;
               hacc_d = hnext;
               sat_d  = sat_now;
               ecnt_d = sel_edge ? ecnt_q + 1'b1 : ecnt_q;
               tmo_d  = sel_edge ? '0 : tmo_q + 1'b1;
            end
         default: if (ack) begin
            rdy_d   = 1'b0;
            state_d = start ? ARM : IDLE;
            tmo_d   = '0;
         end
      endcase
      if (post_res || post_tmo) begin
         state_d = DONE;
         rdy_d   = 1'b1;
         tout_d  = post_tmo;
         sout_d  = post_res & sat_now;
         lout_d  = d_q;
         pout_d  = post_tmo ? '0 : pnext;
         hout_d  = post_tmo ? '0 : hnext;
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         {esel_q, sat_q, pacc_q, hacc_q, ecnt_q, tmo_q} <= '0;
         {rdy_q, tout_q, sout_q, lout_q, pout_q, hout_q} <= '0;
      end else begin
         state_q <= state_d;
         esel_q  <= esel_d;
         sat_q   <= sat_d;
         pacc_q  <= pacc_d;
         hacc_q  <= hacc_d;
         ecnt_q  <= ecnt_d;
         tmo_q   <= tmo_d;
         rdy_q   <= rdy_d;
         tout_q  <= tout_d;
         sout_q  <= sout_d;
         lout_q  <= lout_d;
         pout_q  <= pout_d;
         hout_q  <= hout_d;
      end
   assign measurement_ready   = rdy_q;
   assign period_count_out    = pout_q;
   assign high_time_count_out = hout_q;
   assign timeout_out         = tout_q;
   assign saturated_out       = sout_q;
   assign level_out           = lout_q;
endmodule

// File: tb/tb_multi_period_measurement_unit.sv
// tb_multi_period_measurement_unit: directed checks of three parameterisations sharing one signal source.
module tb_multi_period_measurement_unit;
   logic        clk = 1'b0, reset = 1'b1, esel = 1'b0, sig = 1'b0;
   logic [2:0]  start = '0, ack = '0, rdy, tmo, sat, lvl;
   logic [31:0] pc0, hc0, pc2, hc2;
   logic [7:0]  pc8, hc8;
   int          nvec = 0, nerr = 0;
   int          per = 100, hi = 30, ph = 0;
   logic        gen_en = 1'b1, hold_val = 1'b0, gl_en = 1'b0;

   always #5 clk = ~clk;

   multi_period_measurement_unit #(.COUNT_W(32), .AVG_LOG2(0), .TIMEOUT(1000)) u0 (
      .clk(clk), .reset(reset), .start(start[0]), .ack(ack[0]), .edge_sel(esel), .signal_in(sig),
      .measurement_ready(rdy[0]), .period_count_out(pc0), .high_time_count_out(hc0),
      .timeout_out(tmo[0]), .saturated_out(sat[0]), .level_out(lvl[0]));
   multi_period_measurement_unit #(.COUNT_W(8), .AVG_LOG2(0), .TIMEOUT(1000)) u8 (
      .clk(clk), .reset(reset), .start(start[1]), .ack(ack[1]), .edge_sel(esel), .signal_in(sig),
      .measurement_ready(rdy[1]), .period_count_out(pc8), .high_time_count_out(hc8),
      .timeout_out(tmo[1]), .saturated_out(sat[1]), .level_out(lvl[1]));
   multi_period_measurement_unit #(.COUNT_W(32), .AVG_LOG2(2), .TIMEOUT(1000)) u2 (
      .clk(clk), .reset(reset), .start(start[2]), .ack(ack[2]), .edge_sel(esel), .signal_in(sig),
      .measurement_ready(rdy[2]), .period_count_out(pc2), .high_time_count_out(hc2),
      .timeout_out(tmo[2]), .saturated_out(sat[2]), .level_out(lvl[2]));

   initial forever begin
      @(negedge clk);
      if (gen_en) begin
         ph  = (ph + 1 >= per) ? 0 : ph + 1;
         sig = (ph < hi) && !(gl_en && (ph == 10 || ph == 11));
      end else sig = hold_val;
   end

   task automatic wait_rdy(input int k, input int lim, output int cyc);
      cyc = 0;
      while (!rdy[k] && cyc < lim) begin
         @(negedge clk);
         cyc++;
      end
      if (!rdy[k]) begin
         nvec++; nerr++;
         $display("FAIL wait_ready[%0d]: got ready=0 after %0d cycles, expected ready=1", k, cyc);
      end
   endtask

   task automatic do_ack(input int k);
      @(negedge clk); ack[k] = 1'b1;
      @(negedge clk); ack[k] = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      nvec++;
      if ({rdy, pc0, hc0, tmo, sat, lvl, pc8, hc2} !== '0) begin
         nerr++;
         $display("FAIL reset_outputs: got rdy=%b pc0=%0d hc0=%0d tmo=%b sat=%b lvl=%b expected all 0", rdy, pc0, hc0, tmo, sat, lvl);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic;
      int c;
      start[0] = 1'b1;
      wait_rdy(0, 400, c);
      nvec++; if (pc0 !== 32'd100) begin nerr++; $display("FAIL basic_period: got %0d expected 100", pc0); end
      nvec++; if (hc0 !== 32'd30) begin nerr++; $display("FAIL basic_high: got %0d expected 30", hc0); end
      nvec++; if ({tmo[0], sat[0], lvl[0]} !== 3'b001) begin nerr++; $display("FAIL basic_flags: got tmo/sat/lvl=%b expected 001", {tmo[0], sat[0], lvl[0]}); end
      do_ack(0);
      nvec++; if (rdy[0] !== 1'b0) begin nerr++; $display("FAIL basic_ack: got ready=%b expected 0", rdy[0]); end
      wait_rdy(0, 400, c);
      nvec++; if ({pc0, hc0} !== {32'd100, 32'd30}) begin nerr++; $display("FAIL basic_second: got %0d/%0d expected 100/30", pc0, hc0); end
      do_ack(0);
      start[0] = 1'b0;
   endtask

   task automatic test_avg_falling;
      int c;
      per = 250; hi = 100;
      repeat (600) @(negedge clk);
      esel = 1'b1; start[2] = 1'b1;
      repeat (300) @(negedge clk);
      esel = 1'b0;
      wait_rdy(2, 2000, c);
      nvec++; if (pc2 !== 32'd1000) begin nerr++; $display("FAIL avg_period: got %0d expected 1000", pc2); end
      nvec++; if (hc2 !== 32'd400) begin nerr++; $display("FAIL avg_high: got %0d expected 400", hc2); end
      nvec++; if ({tmo[2], sat[2], lvl[2]} !== 3'b000) begin nerr++; $display("FAIL avg_flags: got tmo/sat/lvl=%b expected 000", {tmo[2], sat[2], lvl[2]}); end
      do_ack(2);
      start[2] = 1'b0;
   endtask

   task automatic test_saturation;
      int c;
      per = 300; hi = 200;
      repeat (700) @(negedge clk);
      start[1] = 1'b1;
      wait_rdy(1, 1000, c);
      nvec++; if (pc8 !== 8'd255) begin nerr++; $display("FAIL sat_period: got %0d expected 255", pc8); end
      nvec++; if (hc8 !== 8'd200) begin nerr++; $display("FAIL sat_high: got %0d expected 200", hc8); end
      nvec++; if ({tmo[1], sat[1]} !== 2'b01) begin nerr++; $display("FAIL sat_flags: got tmo/sat=%b expected 01", {tmo[1], sat[1]}); end
      do_ack(1);
      start[1] = 1'b0;
   endtask

   task automatic test_timeout;
      int c;
      gen_en = 1'b0; hold_val = 1'b1;
      repeat (20) @(negedge clk);
      start[0] = 1'b1;
      wait_rdy(0, 1200, c);
      nvec++; if (c !== 1001) begin nerr++; $display("FAIL tmo_latency: got %0d cycles expected 1001", c); end
      nvec++; if ({pc0, hc0} !== 64'd0) begin nerr++; $display("FAIL tmo_counts: got %0d/%0d expected 0/0", pc0, hc0); end
      nvec++; if ({tmo[0], sat[0], lvl[0]} !== 3'b101) begin nerr++; $display("FAIL tmo_flags: got tmo/sat/lvl=%b expected 101", {tmo[0], sat[0], lvl[0]}); end
      do_ack(0);
      start[0] = 1'b0;
      gen_en = 1'b1;
   endtask

   task automatic test_abort_reset;
      int c;
      per = 100; hi = 30;
      repeat (300) @(negedge clk);
      start[0] = 1'b1;
      wait_rdy(0, 400, c);
      do_ack(0);
      repeat (150) @(negedge clk);
      start[0] = 1'b0;
      repeat (2) @(negedge clk);
      nvec++; if ({rdy[0], pc0} !== {1'b0, 32'd100}) begin nerr++; $display("FAIL abort_kept: got rdy=%b period=%0d expected 0/100", rdy[0], pc0); end
      repeat (300) @(negedge clk);
      nvec++; if (rdy[0] !== 1'b0) begin nerr++; $display("FAIL abort_idle: got ready=%b expected 0", rdy[0]); end
      start[0] = 1'b1;
      wait_rdy(0, 400, c);
      nvec++; if ({pc0, hc0} !== {32'd100, 32'd30}) begin nerr++; $display("FAIL abort_rerun: got %0d/%0d expected 100/30", pc0, hc0); end
      do_ack(0);
      repeat (150) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      nvec++;
      if ({rdy[0], pc0, hc0, tmo[0], sat[0], lvl[0]} !== '0) begin
         nerr++;
         $display("FAIL midreset_outputs: got rdy=%b %0d/%0d tmo=%b sat=%b lvl=%b expected all 0", rdy[0], pc0, hc0, tmo[0], sat[0], lvl[0]);
      end
      reset = 1'b0;
      wait_rdy(0, 400, c);
      nvec++; if ({pc0, hc0} !== {32'd100, 32'd30}) begin nerr++; $display("FAIL midreset_rerun: got %0d/%0d expected 100/30", pc0, hc0); end
      do_ack(0);
      start[0] = 1'b0;
   endtask

`ifdef GLITCH_FILTER_EN
   task automatic test_glitch;
      int c;
      logic seen;
      gl_en = 1'b1;
      repeat (300) @(negedge clk);
      start[0] = 1'b1;
      wait_rdy(0, 400, c);
      nvec++; if ({pc0, hc0} !== {32'd100, 32'd30}) begin nerr++; $display("FAIL glitch_first: got %0d/%0d expected 100/30", pc0, hc0); end
      do_ack(0);
      seen = 1'b0;
      repeat (60) begin
         @(negedge clk);
         seen |= rdy[0];
      end
      nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL glitch_extra: got ready=%b expected 0", seen); end
      wait_rdy(0, 400, c);
      nvec++; if ({pc0, hc0} !== {32'd100, 32'd30}) begin nerr++; $display("FAIL glitch_second: got %0d/%0d expected 100/30", pc0, hc0); end
      do_ack(0);
      start[0] = 1'b0;
      gl_en = 1'b0;
   endtask
`endif

   initial begin
      test_reset;
      repeat (200) @(negedge clk);
      test_basic;
      test_avg_falling;
      test_saturation;
      test_timeout;
      test_abort_reset;
`ifdef GLITCH_FILTER_EN
      test_glitch;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/multi_period_measurement_unit.md
Name: multi_period_measurement_unit

Overview:
Parametrised successor to the single-period frequency/duty measurement block. It measures period and high time of one digital input, optionally accumulated over 2^AVG_LOG2 consecutive periods, with selectable trigger edge. It also has a dead-signal timeout, saturation reporting and a ready/ack handshake to the M1 register interface. It sits between the pin synchroniser domain and the MCU-side register bank.

Parameters:
COUNT_W, 32, width of the period and high-time result counters.
AVG_LOG2, 0, log2 of the number of periods accumulated per result (legal 0..8).
TIMEOUT, 50_000_000, clk cycles without a selected edge before a timeout result is posted (>=2).
FILT_LEN, 4, glitch-filter stability length in clk cycles (used only with the optional feature; >=1).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  level enable; high = measure, low = abort/stop
ack  input  1  single-cycle pulse from MCU consuming the posted result
edge_sel  input  1  trigger edge: 0 = rising, 1 = falling
signal_in  input  1  asynchronous signal under test
measurement_ready  output  1  result valid, held until ack
period_count_out  output  COUNT_W  clk cycles spanned by 2^AVG_LOG2 periods
high_time_count_out  output  COUNT_W  clk cycles the signal was high within those periods
timeout_out  output  1  result is a timeout (no edge for TIMEOUT cycles)
saturated_out  output  1  a counter saturated during this result
level_out  output  1  synchronised signal level at the moment the result was latched

Behaviour:
- Reset (async, any time, including mid-measurement): state=IDLE; all outputs, counters and synchroniser stages = 0.
- Input path: 2-FF synchroniser, then a 1-cycle delay register for edge detect. The pipeline is identical for every edge, so counts are exact. measurement_ready rises 4 clk after the terminating edge is first sampled on signal_in.
- edge_sel is captured on the IDLE->ARM transition. Changes afterwards are ignored until the next IDLE.
- States:
  - IDLE: counters held. start=1 -> ARM.
  - ARM: wait for selected edge. On edge: period_acc=0, high_acc=0, edge_cnt=0, tmo_cnt=0, sat=0 -> MEASURE.
  - MEASURE: every cycle, period_acc+=1 and high_acc+=1 when the synchronised level is 1. On a selected edge, edge_cnt+=1 and tmo_cnt=0.
    - When edge_cnt reaches 2^AVG_LOG2, latch period_acc+1 and high_acc+(level?1:0) into the outputs, set ready=1, timeout_out=0, saturated_out=sat, level_out=level -> DONE.
  - DONE: outputs frozen; selected edges ignored. ack -> ready=0, then ARM if start=1 else IDLE (continuous mode). The edge coincident with ack is not used to arm.
- Timeout: tmo_cnt increments in ARM and MEASURE and clears on each selected edge. When tmo_cnt==TIMEOUT-1: period_count_out=0, high_time_count_out=0, timeout_out=1, level_out=level, saturated_out=0, ready=1 -> DONE.
- Saturation: each accumulator sticks at 2^COUNT_W-1 and does not wrap. Any saturating increment sets sat.
- Abort: start=0 in ARM/MEASURE -> IDLE next cycle. Outputs and ready are unchanged, so a previous unacked result survives. start=0 in DONE: remain in DONE until ack, then -> IDLE.
- ack while ready=0: ignored. ack in the same cycle as a result latch: the latch wins and ready stays 1.
- Terminating edge and timeout in the same cycle: the edge wins and a normal result is posted.

Optional Feature:
GLITCH_FILTER_EN.
- Defined: after the synchroniser, the filtered level changes only when the synchronised input has held the new value for FILT_LEN consecutive cycles. Shorter pulses are discarded. Edge detect, high-time counting and level_out use the filtered level, adding FILT_LEN cycles of fixed latency.
- Undefined: no filter, no FILT_LEN logic; latency as stated above.

Test Plan:
1. AVG_LOG2=0, rising: signal period 100 clk, high 30, start=1 -> ready with period=100, high=30, timeout=0, sat=0; ack -> next result 100/30.
2. AVG_LOG2=2, edge_sel=1: period 250, high 100 -> period=1000, high=400 after 4 falling-edge periods.
3. TIMEOUT=1000, signal_in held 1 after start -> ready at tmo_cnt=999 with period=0, high=0, timeout=1, level_out=1.
4. COUNT_W=8, period 300, high 200 -> period=255, high=200, saturated_out=1.
5. start dropped mid-MEASURE, then reraised; reset pulsed mid-MEASURE -> IDLE with old result kept; after reset all outputs 0; the following measurement is correct (100/30).
6. GLITCH_FILTER_EN, FILT_LEN=4: 100/30 signal plus 2-clk low glitches inside the high phase -> period=100, high=30, no extra result.
